convolution_p: RTL and testbench

Parametrised 3x3 convolution engine: the next generation of the single-channel, two-filter convolution top. It accepts a pre-padded S x S feature map as a raster pixel stream, forms 3x3 windows from internal line buffers, and computes NF filters in parallel with double-buffered weights. It adds stride-2 and optional ReLU output modes. It sits between the feature-map input stream and the output/accumulation buffers.

---
 rtl/convolution_p.sv | 247 ++++++++++++++++++++++++
 tb/tb_convolution_p.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolution_p.sv
// 3x3 convolution engine over a pre-padded SxS raster stream with NF filters in parallel.
// Double-buffered weights, stride-1/2 output selection and optional ReLU.
module convolution_p #(
    parameter int M  = 8,
    parameter int S  = 482,
    parameter int NF = 2,
    parameter int OW = 2*M+4
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic [M-1:0]     din,
    input  logic             valid_in,
    input  logic [M-1:0]     w_din,
    input  logic             w_valid,
    input  logic             w_commit,
    input  logic             stride2,
    input  logic             relu_en,
    output logic [NF*OW-1:0] dout,
    output logic             valid_out,
    output logic             frame_done,
    output logic             busy,
    output logic             commit_pending
);

    localparam int XW = (S > 1) ? $clog2(S) : 1;
    localparam int NW = 9 * NF;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [XW-1:0] X_MAX   = XW'(S - 1);
    localparam logic [XW-1:0] X_LAST2 = XW'((((S - 1) % 2) == 0) ? (S - 1) : (S - 2));
    localparam logic [XW-1:0] X_TWO   = XW'(2);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [IW-1:0] W_MAX   = IW'(NW - 1);
    localparam logic [IW-1:0] W_ONE   = IW'(1);

    logic [XW-1:0] x_q, x_d, y_q, y_d;
    logic          busy_q, busy_d;
    logic          stride_q, stride_d;
    logic          relu_q, relu_d;
    logic          pend_q, pend_d;
    logic [IW-1:0] widx_q, widx_d;

    logic [M-1:0] lb0_q [S];
    logic [M-1:0] lb1_q [S];

    logic [8:0][M-1:0]      win_q, win_d;
    logic [NW-1:0][M-1:0]   shadow_q, shadow_d;
    logic [NW-1:0][M-1:0]   active_q, active_d;
    logic [NW-1:0][2*M-1:0] prod_q, prod_d;

    logic s1_valid_q, s1_valid_d, s1_done_q, s1_done_d;
    logic s2_valid_q, s2_valid_d, s2_done_q, s2_done_d, s2_relu_q, s2_relu_d;

    logic [NF*OW-1:0] dout_q, dout_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;

    logic                 first_pix_s, last_pix_s, emit_s, done_win_s;
    logic                 copy_req_s, copy_s;
    logic [NF-1:0][OW-1:0] acc_s;

    // Pixel counters, frame state and per-frame mode latches
    always_comb begin
        first_pix_s = valid_in && (x_q == {XW{1'b0}}) && (y_q == {XW{1'b0}});
        last_pix_s  = valid_in && (x_q == X_MAX) && (y_q == X_MAX);
        x_d = x_q;
        y_d = y_q;
        if (valid_in) begin
            if (x_q == X_MAX) begin
                x_d = {XW{1'b0}};
                if (y_q == X_MAX) begin
                    y_d = {XW{1'b0}};
                end else begin
                    y_d = y_q + X_ONE;
                end
            end else begin
                x_d = x_q + X_ONE;
            end
        end else begin
            x_d = x_q;
        end
        if (first_pix_s) begin
            busy_d   = 1'b1;
            stride_d = stride2;
            relu_d   = relu_en;
        end else begin
            busy_d   = last_pix_s ? 1'b0 : busy_q;
            stride_d = stride_q;
            relu_d   = relu_q;
        end
    end

    // Window emission decision; x-2 and y-2 share parity with x and y
    always_comb begin
        emit_s     = 1'b0;
        done_win_s = 1'b0;
        if (valid_in && (x_q >= X_TWO) && (y_q >= X_TWO)) begin
            if (stride_q) begin
                emit_s     = ~x_q[0] & ~y_q[0];
                done_win_s = (x_q == X_LAST2) && (y_q == X_LAST2);
            end else begin
                emit_s     = 1'b1;
                done_win_s = (x_q == X_MAX) && (y_q == X_MAX);
            end
        end else begin
            emit_s     = 1'b0;
            done_win_s = 1'b0;
        end
        s1_valid_d = emit_s;
        s1_done_d  = done_win_s;
    end

    // Window shift: new column is {row y-2, row y-1, row y} at column x
    always_comb begin
        win_d = win_q;
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r+1];
                win_d[3*r + 1] = win_q[3*r+2];
            end
            win_d[2] = lb1_q[x_q];
            win_d[5] = lb0_q[x_q];
            win_d[8] = din;
        end else begin
            win_d = win_q;
        end
    end

    // Shadow write and shadow-to-active copy; a word written on the copy edge is included
    always_comb begin
        shadow_d = shadow_q;
        if (w_valid) begin
            shadow_d[widx_q] = w_din;
        end else begin
            shadow_d = shadow_q;
        end
        copy_req_s = pend_q | w_commit;
        copy_s     = copy_req_s & (first_pix_s | (~busy_q & ~s1_valid_q & ~s2_valid_q));
        pend_d     = copy_req_s & ~copy_s;
        if (copy_s) begin
            widx_d   = {IW{1'b0}};
            active_d = shadow_d;
        end else if (w_valid) begin
            widx_d   = (widx_q == W_MAX) ? {IW{1'b0}} : (widx_q + W_ONE);
            active_d = active_q;
        end else begin
            widx_d   = widx_q;
            active_d = active_q;
        end
    end

    // Stage 2: signed tap-by-weight products for every filter
    always_comb begin
        prod_d = prod_q;
        for (int f = 0; f < NF; f++) begin
            for (int i = 0; i < 9; i++) begin
                prod_d[f*9 + i] = $signed(win_q[i]) * $signed(active_q[f*9 + i]);
            end
        end
        s2_valid_d = s1_valid_q;
        s2_done_d  = s1_done_q;
        s2_relu_d  = relu_q;
    end

    // Stage 3: sign-extended sum per filter, then optional ReLU clamp
    always_comb begin
        acc_s  = {(NF*OW){1'b0}};
        dout_d = dout_q;
        for (int f = 0; f < NF; f++) begin
            for (int i = 0; i < 9; i++) begin
                acc_s[f] = acc_s[f] + OW'($signed(prod_q[f*9 + i]));
            end
        end
        if (s2_valid_q) begin
            for (int f = 0; f < NF; f++) begin
                if (s2_relu_q && acc_s[f][OW-1]) begin
                    dout_d[f*OW +: OW] = {OW{1'b0}};
                end else begin
                    dout_d[f*OW +: OW] = acc_s[f];
                end
            end
        end else begin
            dout_d = dout_q;
        end
        valid_out_d  = s2_valid_q;
        frame_done_d = s2_valid_q & s2_done_q;
    end

    // Line buffer memories; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb0_q[x_q] <= din;
            lb1_q[x_q] <= lb0_q[x_q];
        end
    end

    // State, weight banks and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            x_q          <= {XW{1'b0}};
            y_q          <= {XW{1'b0}};
            busy_q       <= 1'b0;
            stride_q     <= 1'b0;
            relu_q       <= 1'b0;
            pend_q       <= 1'b0;
            widx_q       <= {IW{1'b0}};
            win_q        <= {(9*M){1'b0}};
            shadow_q     <= {(NW*M){1'b0}};
            active_q     <= {(NW*M){1'b0}};
            prod_q       <= {(NW*2*M){1'b0}};
            s1_valid_q   <= 1'b0;
            s1_done_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_done_q    <= 1'b0;
            s2_relu_q    <= 1'b0;
            dout_q       <= {(NF*OW){1'b0}};
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            stride_q     <= stride_d;
            relu_q       <= relu_d;
            pend_q       <= pend_d;
            widx_q       <= widx_d;
            win_q        <= win_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            prod_q       <= prod_d;
            s1_valid_q   <= s1_valid_d;
            s1_done_q    <= s1_done_d;
            s2_valid_q   <= s2_valid_d;
            s2_done_q    <= s2_done_d;
            s2_relu_q    <= s2_relu_d;
            dout_q       <= dout_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout           = dout_q;
    assign valid_out      = valid_out_q;
    assign frame_done     = frame_done_q;
    assign busy           = busy_q;
    assign commit_pending = pend_q;

endmodule

// File: tb/tb_convolution_p.sv
// Scoreboard bench for convolution_p: a frame-level reference model pushes expected
// results when pixels are issued; a monitor pops and compares when valid_out appears.
module tb_convolution_p;
    localparam int M  = 8;
    localparam int S  = 6;
    localparam int NF = 2;
    localparam int OW = 2*M+4;
    localparam int NW = 9*NF;
    localparam int LE = (((S-1) % 2) == 0) ? (S-1) : (S-2);

    logic             clk = 1'b0;
    logic             Rst_n;
    logic [M-1:0]     din;
    logic             valid_in, w_valid, w_commit, stride2, relu_en;
    logic [M-1:0]     w_din;
    logic [NF*OW-1:0] dout;
    logic             valid_out, frame_done, busy, commit_pending;

    always #5 clk = ~clk;

    convolution_p #(.M(M), .S(S), .NF(NF), .OW(OW)) dut (
        .clk(clk), .Rst_n(Rst_n), .din(din), .valid_in(valid_in),
        .w_din(w_din), .w_valid(w_valid), .w_commit(w_commit),
        .stride2(stride2), .relu_en(relu_en), .dout(dout),
        .valid_out(valid_out), .frame_done(frame_done), .busy(busy),
        .commit_pending(commit_pending)
    );

    typedef struct {
        logic [NF*OW-1:0] d;
        logic             done;
        int               at;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // reference model state
    int shadow[NW];
    int active[NW];
    int wbuf[NW];
    int widx, px, py, last_emit;
    bit pend, m_stride, m_relu;
    int fm[S][S];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // monitor: every presented output must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) chk("frame_done_needs_valid", valid_out, 1);
        if (valid_out) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid_out: got dout %0h, required no output (cycle %0d)", dout, cyc);
            end else begin
                e = q.pop_front();
                chk("dout", dout, e.d);
                chk("frame_done", frame_done, e.done);
                chk("latency_cycle", cyc, e.at);
            end
        end
    end

    function automatic bit idle_now();
        return (px == 0) && (py == 0) && (cyc >= last_emit + 3);
    endfunction

    function automatic int pixval(input int mode, input int x, input int y);
        if (mode == 0) return x + y*S;
        else if (mode == 1) return 127;
        else return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            shadow[i] = 0;
            active[i] = 0;
        end
        widx = 0; px = 0; py = 0; pend = 0;
        m_stride = 0; m_relu = 0; last_emit = -100;
    endtask

    task automatic drive_pix(input int p);
        exp_t e;
        int   acc;
        if (px == 0 && py == 0) begin
            m_stride = stride2;
            m_relu   = relu_en;
            if (pend) begin
                active = shadow;
                widx   = 0;
                pend   = 0;
            end
        end
        din      = M'(p);
        valid_in = 1'b1;
        fm[py][px] = p;
        if (px >= 2 && py >= 2 && (!m_stride || ((px % 2) == 0 && (py % 2) == 0))) begin
            e.d = '0;
            for (int f = 0; f < NF; f++) begin
                acc = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc += fm[py-2+r][px-2+c] * active[f*9 + r*3 + c];
                if (m_relu && acc < 0) acc = 0;
                e.d[f*OW +: OW] = acc[OW-1:0];
            end
            e.done = m_stride ? (px == LE && py == LE) : (px == S-1 && py == S-1);
            e.at   = cyc + 3;
            q.push_back(e);
            last_emit = cyc;
        end
        if (px == S-1) begin
            px = 0;
            py = (py == S-1) ? 0 : py + 1;
        end else begin
            px = px + 1;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic load_w(input int n, input bit commit_last);
        for (int i = 0; i < n; i++) begin
            w_din    = M'(wbuf[i]);
            w_valid  = 1'b1;
            w_commit = commit_last && (i == n-1);
            shadow[widx] = wbuf[i];
            widx = (widx + 1) % NW;
            if (w_commit) begin
                if (idle_now()) begin
                    active = shadow;
                    widx   = 0;
                end else begin
                    pend = 1;
                end
            end
            @(posedge clk); #1;
        end
        w_valid  = 1'b0;
        w_commit = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int gaps);
        for (int y = 0; y < S; y++) begin
            for (int x = 0; x < S; x++) begin
                drive_pix(pixval(mode, x, y));
                if (x == 0 && y == 0) begin
                    chk("busy_rise", busy, 1);
                    chk("commit_pending_at_start", commit_pending, pend);
                end
                if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
                    @(posedge clk); #1;
                end
            end
        end
        chk("busy_fall", busy, 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d outputs missing, required 0", q.size());
            q.delete();
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; valid_in = 1'b0; w_valid = 1'b0; w_commit = 1'b0;
        while (q.size() > 0 && q[$].at >= cyc + 1) void'(q.pop_back());
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_commit_pending", commit_pending, 0);
        @(posedge clk); #1;
        Rst_n = 1'b1;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < NW; i++) wbuf[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; din = '0; valid_in = 1'b0; w_din = '0;
        w_valid = 1'b0; w_commit = 1'b0; stride2 = 1'b0; relu_en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // identity / box filters, idle commit with the final word
        for (int i = 0; i < NW; i++) wbuf[i] = (i < 9) ? ((i == 4) ? 1 : 0) : 1;
        load_w(NW, 1'b1);
        chk("commit_pending_idle", commit_pending, 0);
        run_frame(0, 0);
        wait_drain();

        // stride 2 with valid_in toggling
        stride2 = 1'b1;
        run_frame(2, 1);
        wait_drain();

        // extreme signed range, ReLU off then on
        for (int i = 0; i < NW; i++) wbuf[i] = -128;
        stride2 = 1'b0;
        load_w(NW, 1'b1);
        run_frame(1, 0);
        wait_drain();
        relu_en = 1'b1;
        run_frame(1, 0);
        wait_drain();

        // partial load committed idle, then a full load must start at index 0
        relu_en = 1'b0;
        rand_weights();
        load_w(5, 1'b1);
        run_frame(2, 0);
        wait_drain();
        rand_weights();
        load_w(NW, 1'b1);
        run_frame(2, 2);
        wait_drain();

        // mid-frame commit, back-to-back second frame applies it
        rand_weights();
        fork
            run_frame(2, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                load_w(NW, 1'b1);
            end
        join
        chk("commit_pending_held", commit_pending, 1);
        run_frame(2, 0);
        wait_drain();

        // random modes, gaps and weights
        for (int k = 0; k < 3; k++) begin
            rand_weights();
            load_w(NW, 1'b1);
            stride2 = 1'($urandom_range(0, 1));
            relu_en = 1'($urandom_range(0, 1));
            run_frame(2, 2);
            wait_drain();
        end

        // reset mid-frame; next pixel is (0,0) and weight banks are cleared
        stride2 = 1'b0;
        relu_en = 1'b0;
        for (int i = 0; i < 20; i++) drive_pix(pixval(2, 0, 0));
        do_reset();
        run_frame(2, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
